// File: rtl/button_event_classifier.sv
// Turns a debounced button level into short / long / double-click event pulses,
// plus a held level for long presses and a busy flag. All outputs are registered.
module button_event_classifier #(
  parameter int LONG_COUNT = 12500000,
  parameter int GAP_COUNT  = 6250000
) (
  input  logic CLK,
  input  logic i_RST,
  input  logic i_BUT,
  output logic o_SHORT,
  output logic o_LONG,
  output logic o_DOUBLE,
  output logic o_HELD,
  output logic o_BUSY
);

  localparam int MAX_COUNT = (LONG_COUNT > GAP_COUNT) ? LONG_COUNT : GAP_COUNT;
  localparam int TW        = $clog2(MAX_COUNT) + 1;

  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_COUNT - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS1   = 3'd1,
    LONG     = 3'd2,
    WAIT_GAP = 3'd3,
    PRESS2   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic            r_prev;
  logic            w_rise;

  logic            w_short;
  logic            w_long;
  logic            w_double;
  logic            w_held;
  logic            w_busy;

  logic            r_short;
  logic            r_long;
  logic            r_double;
  logic            r_held;
  logic            r_busy;

  assign w_rise = i_BUT & ~r_prev;

  // State, timer, edge-detect history and registered outputs
  always_ff @(posedge CLK) begin
    if (i_RST) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_prev   <= i_BUT;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_held   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_prev   <= i_BUT;
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      r_held   <= w_held;
      r_busy   <= w_busy;
    end
  end

  // Timer only runs in PRESS1 and WAIT_GAP; both leave at their limit, so it cannot wrap
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_double    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = PRESS1;
        end
      end

      PRESS1: begin
        if (!i_BUT) begin
          w_state_nxt = WAIT_GAP;
        end else if (r_timer == LONG_LAST) begin
          w_state_nxt = LONG;
          w_long      = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      LONG: begin
        if (!i_BUT) begin
          w_state_nxt = IDLE;
        end
      end

      WAIT_GAP: begin
        // A new press beats the timeout when both land on the same edge
        if (i_BUT) begin
          w_state_nxt = PRESS2;
        end else if (r_timer == GAP_LAST) begin
          w_state_nxt = IDLE;
          w_short     = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      PRESS2: begin
        if (!i_BUT) begin
          w_state_nxt = IDLE;
          w_double    = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_held = (w_state_nxt == LONG);
    w_busy = (w_state_nxt != IDLE);
  end

  assign o_SHORT  = r_short;
  assign o_LONG   = r_long;
  assign o_DOUBLE = r_double;
  assign o_HELD   = r_held;
  assign o_BUSY   = r_busy;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier: each step drives i_BUT for one edge,
// queues the expected {SHORT,LONG,DOUBLE,HELD,BUSY} and checks it after the edge.
module tb_button_event_classifier;

  localparam int LONG_COUNT = 10;
  localparam int GAP_COUNT  = 6;

  logic CLK = 1'b0;
  logic i_RST;
  logic i_BUT;
  logic o_SHORT;
  logic o_LONG;
  logic o_DOUBLE;
  logic o_HELD;
  logic o_BUSY;

  int total = 0;
  int bad   = 0;
  string tag = "init";
  logic [4:0] exp_q[$];

  always #5 CLK = ~CLK;

  button_event_classifier #(
    .LONG_COUNT(LONG_COUNT),
    .GAP_COUNT (GAP_COUNT)
  ) dut (
    .CLK     (CLK),
    .i_RST   (i_RST),
    .i_BUT   (i_BUT),
    .o_SHORT (o_SHORT),
    .o_LONG  (o_LONG),
    .o_DOUBLE(o_DOUBLE),
    .o_HELD  (o_HELD),
    .o_BUSY  (o_BUSY)
  );

  // Expected bit order: {SHORT, LONG, DOUBLE, HELD, BUSY}
  localparam logic [4:0] E_NONE  = 5'b00000;
  localparam logic [4:0] E_BUSY  = 5'b00001;
  localparam logic [4:0] E_SHORT = 5'b10000;
  localparam logic [4:0] E_LONG  = 5'b01011;
  localparam logic [4:0] E_HELD  = 5'b00011;
  localparam logic [4:0] E_DBL   = 5'b00100;

  task automatic tick(input logic but, input logic [4:0] exp);
    logic [4:0] obs;
    logic [4:0] want;
    i_BUT = but;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    obs  = {o_SHORT, o_LONG, o_DOUBLE, o_HELD, o_BUSY};
    want = exp_q.pop_front();
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, want);
    end
  endtask

  task automatic ticks(input int n, input logic but, input logic [4:0] exp);
    for (int i = 0; i < n; i++) tick(but, exp);
  endtask

  initial begin
    i_RST = 1'b1;
    i_BUT = 1'b0;

    tag = "reset";
    ticks(2, 1'b0, E_NONE);
    i_RST = 1'b0;

    tag = "idle";
    ticks(20, 1'b0, E_NONE);

    // Short press: 4 pressed edges, release at f, pulse after edge f+6
    tag = "short";
    ticks(4, 1'b1, E_BUSY);
    ticks(GAP_COUNT, 1'b0, E_BUSY);
    tick(1'b0, E_SHORT);
    ticks(5, 1'b0, E_NONE);

    // Long press held 30 edges
    tag = "long";
    ticks(LONG_COUNT, 1'b1, E_BUSY);
    tick(1'b1, E_LONG);
    ticks(19, 1'b1, E_HELD);
    tick(1'b0, E_NONE);
    ticks(10, 1'b0, E_NONE);

    // Release on exactly the long edge -> short, not long
    tag = "long_edge_release";
    ticks(LONG_COUNT, 1'b1, E_BUSY);
    ticks(GAP_COUNT, 1'b0, E_BUSY);
    tick(1'b0, E_SHORT);
    ticks(5, 1'b0, E_NONE);

    // Double click: press 3, release 3, press 2, release
    tag = "double";
    ticks(3, 1'b1, E_BUSY);
    ticks(3, 1'b0, E_BUSY);
    ticks(2, 1'b1, E_BUSY);
    tick(1'b0, E_DBL);
    ticks(10, 1'b0, E_NONE);

    // Second rise on the WAIT_GAP timer==GAP_COUNT-1 edge -> double wins
    tag = "double_gap_edge";
    ticks(3, 1'b1, E_BUSY);
    ticks(GAP_COUNT, 1'b0, E_BUSY);
    ticks(2, 1'b1, E_BUSY);
    tick(1'b0, E_DBL);
    ticks(10, 1'b0, E_NONE);

    // Third click after a double starts a fresh sequence
    tag = "triple";
    ticks(2, 1'b1, E_BUSY);
    tick(1'b0, E_BUSY);
    ticks(1, 1'b1, E_BUSY);
    tick(1'b0, E_DBL);
    ticks(2, 1'b1, E_BUSY);
    ticks(GAP_COUNT, 1'b0, E_BUSY);
    tick(1'b0, E_SHORT);
    ticks(3, 1'b0, E_NONE);

    // Button held through reset release: no rise, no events
    tag = "held_through_reset";
    i_RST = 1'b1;
    ticks(2, 1'b1, E_NONE);
    i_RST = 1'b0;
    ticks(LONG_COUNT + 5, 1'b1, E_NONE);
    ticks(3, 1'b0, E_NONE);

    // Reset in WAIT_GAP aborts the sequence without a pulse
    tag = "reset_in_gap";
    ticks(2, 1'b1, E_BUSY);
    ticks(2, 1'b0, E_BUSY);
    i_RST = 1'b1;
    tick(1'b0, E_NONE);
    i_RST = 1'b0;
    ticks(GAP_COUNT + 6, 1'b0, E_NONE);

    // Reset during LONG drops HELD/BUSY immediately
    tag = "reset_in_long";
    ticks(LONG_COUNT, 1'b1, E_BUSY);
    tick(1'b1, E_LONG);
    ticks(3, 1'b1, E_HELD);
    i_RST = 1'b1;
    tick(1'b1, E_NONE);
    i_RST = 1'b0;
    ticks(4, 1'b1, E_NONE);
    ticks(3, 1'b0, E_NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_classifier.md
Name: button_event_classifier

Overview:
- Sits directly downstream of the button debouncer.
- Consumes one clean, debounced button level and turns press/release timing into single-cycle event pulses: short press, long press and double click.
- Also provides a held-level output for the long press and a busy flag.
- Outputs drive LED/7-segment/control logic on the board; all timing is counted in CLK cycles.

Parameters:
- LONG_COUNT, 12500000, cycles a press must persist past the rising sample before it is a long press (0.5 s at 25 MHz); must be >= 2.
- GAP_COUNT, 6250000, cycles after a release during which a second press makes a double click (0.25 s at 25 MHz); must be >= 2.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- i_RST  input  1  reset; synchronous, active-high.
- i_BUT  input  1  debounced button level from the debouncer; 1 = pressed.
- o_SHORT  output  1  one-cycle pulse: single short press completed.
- o_LONG  output  1  one-cycle pulse: press reached LONG_COUNT.
- o_DOUBLE  output  1  one-cycle pulse: second press released inside the gap window.
- o_HELD  output  1  level; high while in LONG state.
- o_BUSY  output  1  level; high whenever FSM is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (i_RST=1 at a posedge):
  - state=IDLE, timer=0, all outputs 0.
  - r_prev loads i_BUT, so a button held across reset release causes no press.
  - Reset overrides everything, mid-sequence included; no pulse is emitted for an aborted sequence.
- timer: unsigned, width clog2(max(LONG_COUNT,GAP_COUNT))+1. Cleared on every state change. Incremented each cycle otherwise. It never wraps, because every state that counts exits at its limit.
- r_prev <= i_BUT every cycle. rise = i_BUT & ~r_prev, used only in IDLE.
- Pulses o_SHORT, o_LONG, o_DOUBLE are default 0 each cycle. At most one is set per cycle; they are mutually exclusive by construction.
- FSM (conditions are evaluated on i_BUT as sampled at the posedge):
  - IDLE: rise -> PRESS1.
  - PRESS1:
    - i_BUT=0 -> WAIT_GAP.
    - else if timer==LONG_COUNT-1 -> LONG, with o_LONG=1 and o_HELD=1.
    - else timer++.
  - LONG: i_BUT=0 -> IDLE, o_HELD=0. Otherwise hold; no further pulses however long the button is held.
  - WAIT_GAP:
    - i_BUT=1 -> PRESS2. A press wins over timeout in the same cycle.
    - else if timer==GAP_COUNT-1 -> IDLE, o_SHORT=1.
    - else timer++.
  - PRESS2: i_BUT=0 -> IDLE, o_DOUBLE=1, regardless of hold duration. The timer is not used.
- Latency (let edge t be the first posedge sampling i_BUT=1 in IDLE with r_prev=0):
  - o_LONG is high in the cycle after edge t+LONG_COUNT, if i_BUT=1 at every edge t..t+LONG_COUNT.
  - If i_BUT is first sampled 0 at edge f in PRESS1, o_SHORT is high in the cycle after edge f+GAP_COUNT, provided i_BUT=0 at edges f..f+GAP_COUNT.
  - o_DOUBLE is high in the cycle after the edge that samples release in PRESS2.
- o_BUSY = (state != IDLE), registered alongside state.
- Triple and further clicks: after o_DOUBLE the FSM is in IDLE. The third press starts a fresh sequence.
- Release on exactly the long edge: i_BUT=0 takes priority in PRESS1, giving a short press, not a long one.

Test Plan:
- Bench uses LONG_COUNT=10, GAP_COUNT=6.
- Reset release with i_BUT=0, idle 20 cycles -> all outputs 0, o_BUSY=0.
- Press for 4 edges, release at edge f -> o_BUSY=1 from edge t+1; exactly one o_SHORT pulse in the cycle after edge f+6; no o_LONG, no o_DOUBLE.
- Press held 30 cycles -> o_LONG one pulse after edge t+10; o_HELD=1 from then until the edge sampling release, then 0; no o_SHORT.
- Press 3 edges, release 3 edges, press 2 edges, release -> one o_DOUBLE after the release edge; no o_SHORT; FSM in IDLE.
- Repeat the double-click scenario but make the second rise land exactly on the edge where WAIT_GAP timer==5 -> o_DOUBLE, not o_SHORT.
- Hold i_BUT=1 through reset and after reset -> no pulses, o_BUSY=0. Separately, assert i_RST during WAIT_GAP -> IDLE next edge, no o_SHORT ever emitted.
